// File: rtl/fetch_pc_unit_if.sv
// Purpose : bundles the instruction-memory request/response channel and the
//           fetch-queue output channel of the fetch front end.
// Signals : imem_req_valid/imem_req_addr/imem_req_ready - word fetch request
//           imem_rsp_valid/imem_rsp_data                - in-order fetch response
//           if_valid/if_instr/if_pc/if_ready             - fetch queue head to decode
// Modports: master = fetch unit side, slave = memory/decode side.
interface fetch_pc_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Purpose : instruction-fetch front end. Owns the architectural PC, issues one
//           word fetch at a time, buffers returned words with their PCs in a
//           2-entry queue toward decode, and discards wrong-path fetches when
//           the PC update logic redirects.
// Ports   : clk, rst_n (async, active-low)
//           redirect_i, redirect_pc_i - taken jump/branch and its target
//           pc_o                      - current fetch PC (next address requested)
//           bus (fetch_pc_unit_if.master) - imem request/response + decode queue
//
// state | meaning
// FETCH | request valid on the bus, waiting for memory to accept it
// WAIT  | one request in flight, waiting for its response
// STALL | queue full (2 entries), no request until decode pops one
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [31:0]       pc_o,
    fetch_pc_unit_if.master   bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_drop;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc    [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic        w_accept;
    logic        w_rsp;
    logic        w_pop;
    logic        w_push;
    logic        w_wr_idx;
    logic        w_redirect_drop;
    logic [1:0]  w_count_nxt;
    logic [31:0] w_redirect_pc;

    always_comb begin
        w_accept        = r_req_valid & bus.imem_req_ready;
        w_rsp           = (r_state == WAIT) & bus.imem_rsp_valid;
        w_pop           = (r_count != 2'd0) & bus.if_ready;
        // A response landing in a redirect cycle belongs to the old path.
        w_push          = w_rsp & ~r_drop & ~redirect_i;
        w_count_nxt     = r_count + {1'b0, w_push} - {1'b0, w_pop};
        // Tail slot is head + count; with two slots that is a single XOR.
        w_wr_idx        = r_head ^ r_count[0];
        w_redirect_pc   = {redirect_pc_i[31:2], 2'b00};
        // Something is still (or newly) in flight and must be thrown away.
        w_redirect_drop = w_accept | ((r_state == WAIT) & ~bus.imem_rsp_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= FETCH;
            r_req_valid     <= 1'b1;
            r_pc            <= RESET_PC;
            r_inflight_pc   <= '0;
            r_drop          <= 1'b0;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
            r_fifo_pc[0]    <= '0;
            r_fifo_pc[1]    <= '0;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_instr[w_wr_idx] <= bus.imem_rsp_data;
                r_fifo_pc[w_wr_idx]    <= r_inflight_pc;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end

            if (redirect_i) begin
                r_pc        <= w_redirect_pc;
                r_count     <= 2'd0;
                r_drop      <= w_redirect_drop;
                r_state     <= w_redirect_drop ? WAIT : FETCH;
                r_req_valid <= ~w_redirect_drop;
            end else begin
                r_count <= w_count_nxt;
                unique case (r_state)
                    FETCH: begin
                        if (w_accept) begin
                            r_inflight_pc <= r_pc;
                            r_pc          <= r_pc + 32'd4;
                            r_state       <= WAIT;
                            r_req_valid   <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (w_rsp) begin
                            r_drop <= 1'b0;
                            // Only fetch again if the queue can hold the answer.
                            if (w_count_nxt == 2'd2) begin
                                r_state     <= STALL;
                                r_req_valid <= 1'b0;
                            end else begin
                                r_state     <= FETCH;
                                r_req_valid <= 1'b1;
                            end
                        end
                    end
                    STALL: begin
                        if (w_pop) begin
                            r_state     <= FETCH;
                            r_req_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= FETCH;
                        r_req_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pc_o               = r_pc;
    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = (r_count != 2'd0);
    assign bus.if_instr       = r_fifo_instr[r_head];
    assign bus.if_pc          = r_fifo_pc[r_head];

endmodule
